morse_symbol_producer: RTL and testbench
========================================

// Module: morse_symbol_producer
// PURPOSE
//  Parametrised successor to producer_main. Turns Dot/Dash/Space/EndSeq/Clear button levels into packed Morse codes.
//  Rising edges append 2-bit symbols to an accumulator; EndSeq/Space commit it to a DEPTH-entry FIFO.
//  FIFO output uses a valid/ready handshake to the decoder/display stage.
//  Adds: configurable symbol count, character buffering, overflow/drop flags, optional debounce.
// PARAMETERS
//  MAX_SYMS         5     max symbols per character; code width CW = 2*MAX_SYMS
//  DEPTH            4     FIFO entries (power of 2, >=2)
//  DEBOUNCE_CYCLES  1000  stable cycles required per input (only with MORSE_DEBOUNCE_EN)
// PORTS
//  clk           in   1                 system clock, rising edge
//  Reset         in   1                 asynchronous, active-high reset
//  Dot           in   1                 button level; rising edge = symbol 2'b01
//  Dash          in   1                 button level; rising edge = symbol 2'b10
//  Space         in   1                 rising edge = commit char with word-space flag
//  EndSeq        in   1                 rising edge = commit char
//  Clear         in   1                 rising edge = discard accumulator
//  out_ready     in   1                 consumer accepts head entry
//  outputbits    out  CW                head code; sym0 in [1:0], sym1 in [3:2], ... unused = 2'b00
//  spa_end       out  1                 head entry carries word-space flag
//  out_valid     out  1                 FIFO non-empty
//  sent          out  1                 1-cycle pulse = out_valid & out_ready (pop)
//  sym_count     out  $clog2(MAX_SYMS+1) symbols in accumulator
//  fifo_level    out  $clog2(DEPTH+1)    entries stored
//  sym_overflow  out  1                 sticky: symbol arrived with sym_count==MAX_SYMS
//  drop_err      out  1                 1-cycle pulse: commit lost, FIFO full
// BEHAVIOUR
//  Reset (async): accumulator=0, sym_count=0, FIFO empty, all outputs 0, edge regs 0.
//  Reset mid-operation: accumulator and FIFO contents are lost.
//  Edge detect: per input prev-register. Event when sampled level=1 and prev=0. Action at that same posedge.
//  Held level produces one event only.
//  Priority, same-cycle events: Clear > EndSeq > Space > Dash > Dot. Only the winner acts; the rest are lost.
//  Dot/Dash: if sym_count<MAX_SYMS, write the symbol at slot sym_count and increment.
//    Otherwise ignore the symbol and set sym_overflow.
//  EndSeq: if sym_count==0, no-op. Otherwise push {space=0, code}.
//  Space: always push {space=1, code}; code may be 0 (pure word gap).
//  After any commit attempt, or Clear: accumulator=0, sym_count=0, sym_overflow=0.
//  FIFO: registered storage; head is combinational from the read pointer. Pointers wrap modulo DEPTH.
//  out_valid rises the cycle after the push edge (no extra bubble).
//  Head entry is held stable while out_valid & !out_ready.
//  Full + push, no pop: entry dropped, drop_err=1 for one cycle, accumulator still cleared.
//  Full + push + pop same cycle: both succeed, level unchanged.
//  Empty: out_valid=0; out_ready ignored; outputbits/spa_end hold last head value (don't care).
//  sent pulses on every accepted pop.
// CONFIGURATION
//  MORSE_DEBOUNCE_EN defined:
//    Each of the 5 inputs passes a 2-flop synchroniser and a debounce counter.
//    The filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples.
//    Edge detect runs on the filtered level. Event latency = 2 + DEBOUNCE_CYCLES cycles after the input settles.
//  MORSE_DEBOUNCE_EN undefined:
//    Inputs are assumed synchronous; edge detect runs on raw inputs.
//    DEBOUNCE_CYCLES unused. Event acted on at the first posedge sampling 1.
// TESTING (default params, macro undefined)
//  1. Reset pulse mid-run -> all outputs 0; FIFO empty; next char codes from slot 0.
//  2. Dot x3, EndSeq; consumer ready -> outputbits=10'h015, spa_end=0, sent pulses once.
//     Then Dash x3, EndSeq -> 10'h02A.
//  3. Dash,Dot then Space -> entry 10'h006 spa_end=1.
//     Space with empty accumulator -> entry 10'h000 spa_end=1.
//     EndSeq with empty accumulator -> no push.
//  4. Six Dots then EndSeq -> sym_overflow=1 after the 6th; pushed 10'h155; sym_overflow=0 after the commit.
//  5. out_ready=0: commit 5 chars -> fifo_level 4, drop_err pulse on the 5th, head unchanged.
//     Then push+pop same cycle at full -> level stays 4.
//  6. Dot and Clear rising same cycle -> sym_count=0.
//     Dot held 20 cycles -> sym_count=1 (single event).

Source files
------------

// File: rtl/morse_symbol_producer.sv
// morse_symbol_producer
//   Turns Dot/Dash/Space/EndSeq/Clear button levels into packed Morse codes.
//   Rising edges append 2-bit symbols to an accumulator. EndSeq and Space commit
//   the accumulator to a DEPTH-entry FIFO, which is read out via valid/ready.
//
// Parameters
//   MAX_SYMS         symbols per character (code width CW = 2*MAX_SYMS)
//   DEPTH            FIFO entries (power of 2, >= 2)
//   DEBOUNCE_CYCLES  stable samples required per input (debounce build only)
//
// Build option
//   MORSE_DEBOUNCE_EN  when defined, each input passes a 2-flop synchroniser and a
//                      debounce filter before edge detection. When undefined,
//                      inputs are assumed synchronous and edge-detected directly.
//
// Ports
//   clk           system clock, rising edge
//   Reset         asynchronous active-high reset
//   Dot, Dash     button levels; rising edge appends 2'b01 / 2'b10
//   Space         rising edge commits the character with the word-space flag
//   EndSeq        rising edge commits the character (no-op if empty)
//   Clear         rising edge discards the accumulator
//   out_ready     consumer accepts the head entry
//   outputbits    head code, sym0 in [1:0], sym1 in [3:2], unused = 2'b00
//   spa_end       head entry carries the word-space flag
//   out_valid     FIFO non-empty
//   sent          pop strobe (out_valid & out_ready)
//   sym_count     symbols currently in the accumulator
//   fifo_level    entries currently stored
//   sym_overflow  sticky: symbol arrived with a full accumulator
//   drop_err      one-cycle pulse: commit lost because the FIFO was full
module morse_symbol_producer #(
    parameter int MAX_SYMS        = 5,
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    localparam int CW = 2 * MAX_SYMS,
    localparam int SW = $clog2(MAX_SYMS + 1),
    localparam int LW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Dot,
    input  logic          Dash,
    input  logic          Space,
    input  logic          EndSeq,
    input  logic          Clear,
    input  logic          out_ready,
    output logic [CW-1:0] outputbits,
    output logic          spa_end,
    output logic          out_valid,
    output logic          sent,
    output logic [SW-1:0] sym_count,
    output logic [LW-1:0] fifo_level,
    output logic          sym_overflow,
    output logic          drop_err
);

    // Bit order: 0 Dot, 1 Dash, 2 Space, 3 EndSeq, 4 Clear
    logic [4:0] raw;
    logic [4:0] lvl;
    assign raw = {Clear, EndSeq, Space, Dash, Dot};

`ifdef MORSE_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [4:0]     sync1;
    logic [4:0]     sync2;
    logic [4:0]     filt;
    logic [DBW-1:0] db_cnt [5];

    // Filtered level follows the synchronised input only after
    // DEBOUNCE_CYCLES consecutive samples that differ from it.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 5; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = filt;
`else
    assign lvl = raw;
`endif

    logic [4:0] prev;
    logic [4:0] ev;
    assign ev = lvl & ~prev;

    // Same-cycle priority: Clear > EndSeq > Space > Dash > Dot
    logic       do_clear;
    logic       do_end;
    logic       do_space;
    logic       do_sym;
    logic [1:0] sym_val;
    logic       push_req;
    logic       commit;

    always_comb begin
        do_clear = ev[4];
        do_end   = !ev[4] && ev[3];
        do_space = !ev[4] && !ev[3] && ev[2];
        do_sym   = !ev[4] && !ev[3] && !ev[2] && (ev[1] || ev[0]);
        sym_val  = ev[1] ? 2'b10 : 2'b01;
        push_req = do_space || (do_end && (sym_count != '0));
        commit   = do_clear || do_end || do_space;
    end

    logic [CW-1:0] acc;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            prev         <= '0;
            acc          <= '0;
            sym_count    <= '0;
            sym_overflow <= 1'b0;
        end else begin
            prev <= lvl;
            if (commit) begin
                acc          <= '0;
                sym_count    <= '0;
                sym_overflow <= 1'b0;
            end else if (do_sym) begin
                if (sym_count < SW'(MAX_SYMS)) begin
                    for (int unsigned i = 0; i < MAX_SYMS; i++) begin
                        if (sym_count == SW'(i)) begin
                            acc[2*i +: 2] <= sym_val;
                        end
                    end
                    sym_count <= sym_count + 1'b1;
                end else begin
                    sym_overflow <= 1'b1;
                end
            end
        end
    end

    // FIFO: entry = {space flag, code}
    logic [CW:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign out_valid  = (fifo_level != '0);
    assign full       = (fifo_level == LW'(DEPTH));
    assign pop        = out_valid && out_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok    = push_req && (!full || pop);
    assign sent       = pop;
    assign outputbits = mem[rd_ptr][CW-1:0];
    assign spa_end    = mem[rd_ptr][CW];

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_err   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {do_space, acc};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            drop_err <= push_req && full && !pop;
        end
    end

endmodule

// File: tb/tb_morse_symbol_producer.sv
module tb_morse_symbol_producer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Dot, Dash, Space, EndSeq, Clear, out_ready;
    logic [9:0] outputbits;
    logic       spa_end, out_valid, sent, sym_overflow, drop_err;
    logic [2:0] sym_count;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    // Bench model
    logic [10:0] sb[$];
    logic [9:0]  m_code;
    int          m_cnt;
    logic        m_ovf;
    logic        exp_drop;

    morse_symbol_producer #(
        .MAX_SYMS(5),
        .DEPTH(DEPTH),
        .DEBOUNCE_CYCLES(1000)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .Dot(Dot),
        .Dash(Dash),
        .Space(Space),
        .EndSeq(EndSeq),
        .Clear(Clear),
        .out_ready(out_ready),
        .outputbits(outputbits),
        .spa_end(spa_end),
        .out_valid(out_valid),
        .sent(sent),
        .sym_count(sym_count),
        .fifo_level(fifo_level),
        .sym_overflow(sym_overflow),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (sent === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_sent", 32'd1, 32'd0);
            end else begin
                logic [10:0] e;
                e = sb.pop_front();
                check("head_code", {22'd0, outputbits}, {22'd0, e[9:0]});
                check("head_space", {31'd0, spa_end}, {31'd0, e[10]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_clear();
        m_code = '0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_sym(input logic [1:0] s);
        if (m_cnt < 5) begin
            m_code[2*m_cnt +: 2] = s;
            m_cnt++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_commit(input logic space, input logic same_pop);
        if (space || m_cnt != 0) begin
            if (sb.size() < DEPTH || same_pop) sb.push_back({space, m_code});
            else exp_drop = 1'b1;
        end
        model_clear();
    endtask

    task automatic set_in(input int which, input logic v);
        case (which)
            0: Dot    = v;
            1: Dash   = v;
            2: Space  = v;
            3: EndSeq = v;
            default: Clear = v;
        endcase
    endtask

    task automatic press(input int which);
        set_in(which, 1'b1);
        tick();
        check("drop_err", {31'd0, drop_err}, {31'd0, exp_drop});
        check("sym_count", {29'd0, sym_count}, m_cnt);
        check("sym_overflow", {31'd0, sym_overflow}, {31'd0, m_ovf});
        exp_drop = 1'b0;
        set_in(which, 1'b0);
        tick();
    endtask

    task automatic dot();   model_sym(2'b01);          press(0); endtask
    task automatic dash();  model_sym(2'b10);          press(1); endtask
    task automatic space(); model_commit(1'b1, 1'b0);  press(2); endtask
    task automatic endsq(); model_commit(1'b0, 1'b0);  press(3); endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        check("drain_empty", sb.size(), 0);
        tick();
        check("level_after_drain", {29'd0, fifo_level}, 0);
    endtask

    initial begin
        Reset = 1'b1;
        {Dot, Dash, Space, EndSeq, Clear} = '0;
        out_ready = 1'b1;
        exp_drop  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #2;
        check("rst_outputbits", {22'd0, outputbits}, 0);
        check("rst_flags", {26'd0, spa_end, out_valid, sent, sym_overflow, drop_err, 1'b0}, 0);
        check("rst_counts", {26'd0, sym_count, fifo_level}, 0);
        Reset = 1'b0;
        tick();

        // Basic characters
        dot(); dot(); dot(); endsq();
        dash(); dash(); dash(); endsq();
        drain();

        // Space commits, empty commits
        dash(); dot(); space();
        space();
        endsq();
        drain();

        // Accumulator overflow
        repeat (6) dot();
        endsq();
        drain();

        // FIFO full / drop / simultaneous push+pop
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dot();
            if (k % 2 == 1) dash();
            endsq();
        end
        check("full_level", {29'd0, fifo_level}, DEPTH);
        check("full_head", {22'd0, outputbits}, {22'd0, sb[0][9:0]});
        dash();
        out_ready = 1'b1;
        EndSeq = 1'b1;
        model_commit(1'b0, 1'b1);
        tick();
        out_ready = 1'b0;
        EndSeq = 1'b0;
        check("pushpop_level", {29'd0, fifo_level}, DEPTH);
        check("pushpop_drop", {31'd0, drop_err}, 0);
        tick();
        drain();

        // Clear wins over Dot; held Dot counts once
        dot();
        Dot = 1'b1;
        Clear = 1'b1;
        model_clear();
        tick();
        check("clear_wins", {29'd0, sym_count}, 0);
        Dot = 1'b0;
        Clear = 1'b0;
        tick();
        Dot = 1'b1;
        model_sym(2'b01);
        repeat (20) tick();
        check("held_dot", {29'd0, sym_count}, 1);
        Dot = 1'b0;
        model_commit(1'b0, 1'b0);
        press(3);
        drain();

        // Reset mid-run drops accumulator and FIFO contents
        out_ready = 1'b0;
        dash(); endsq();
        dot();
        #1 Reset = 1'b1;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 0);
        check("midrst_level", {29'd0, fifo_level}, 0);
        check("midrst_count", {29'd0, sym_count}, 0);
        check("midrst_code", {22'd0, outputbits}, 0);
        sb.delete();
        model_clear();
        tick();
        Reset = 1'b0;
        tick();
        out_ready = 1'b1;
        dot(); endsq();
        dash(); endsq();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
